// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a STATUS register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_data_out,
    input  logic        memory_write_enable,
    output logic [31:0] read_data,
    output logic        uart_tx
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       tx_byte;
    logic             tx_next, pop, push, baud_done, full, empty, busy;
    logic             hit, wr_txdata, wr_status, clr_overflow;
    logic             unused_bits;

    assign hit          = memory_address[31:3] == BASE_ADDR[31:3];
    assign wr_txdata    = memory_write_enable && hit && !memory_address[2];
    assign wr_status    = memory_write_enable && hit && memory_address[2];
    assign clr_overflow = wr_status && memory_data_out[3];
    assign unused_bits  = ^{memory_address[1:0], memory_data_out[31:8]};

    assign full      = count == CNT_W'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign busy      = state != IDLE;
    assign baud_done = baud_cnt == BAUD_LAST;
    // A full FIFO still takes a write on the edge where the transmitter pops.
    assign push      = wr_txdata && (!full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_txdata && !push) overflow <= 1'b1;
            else if (clr_overflow)  overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= memory_data_out[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
        end else begin
            if (state_next != state || state == IDLE || baud_done) baud_cnt <= '0;
            else                                                   baud_cnt <= baud_cnt + 16'd1;
            if (state_next != state)              bit_idx <= '0;
            else if (state == DATA && baud_done)  bit_idx <= bit_idx + 3'd1;
            if (pop) tx_byte <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            uart_tx <= tx_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = START;
            end
            START: if (baud_done) state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (baud_done && bit_idx == 3'd7) state_next = PARITY;
            PARITY: if (baud_done) state_next = STOP;
`else
            DATA:   if (baud_done && bit_idx == 3'd7) state_next = STOP;
`endif
            STOP: if (baud_done) begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = ^tx_byte;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        read_data = '0;
        if (hit && memory_address[2]) begin
            read_data[0]          = full;
            read_data[1]          = empty;
            read_data[2]          = busy;
            read_data[3]          = overflow;
            read_data[8 +: CNT_W] = count;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register-decode vector table plus frame-level scoreboard for mmio_uart_tx.
// A line monitor rebuilds each frame and compares it against the bytes the bench expects.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] ST   = BASE + 32'd4;
    localparam int          CPB  = 4;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
`else
    localparam int          NBITS = 10;
`endif
    localparam int          FC = NBITS * CPB;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, read_data;
    logic        we, uart_tx;

    int   n_cmp = 0, n_fail = 0, cyc = 0, n_frames = 0;
    int   w, zeros, lows, frames_before;
    bit   mon_busy = 1'b0;
    logic [7:0] sb[$];
    int   starts[$];
    vec_t vecs[12];

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memory_address(addr), .memory_data_out(wdata),
        .memory_write_enable(we), .read_data(read_data), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic wen);
        @(negedge clk);
        addr = a; wdata = d; we = wen;
    endtask

    task automatic idle_bus();
        drive(ST, 32'd0, 1'b0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while ((sb.size() != 0 || mon_busy) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, {31'd0, sb.size() == 0 && !mon_busy}, 32'd1);
    endtask

    // Samples n bit-times of the line; the first sample is the bit value, later ones must match.
    task automatic mon_bit(input int n, output logic v, inout int glitch, inout bit abrt);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (reset) abrt = 1'b1;
            if (k == 0) v = uart_tx;
            else if (uart_tx !== v) glitch++;
        end
    endtask

    task automatic receive_frame();
        logic       v;
        logic [7:0] b, exp;
        int         g = 0;
        bit         a = 1'b0;
        mon_bit(CPB - 1, v, g, a);
        if (v !== 1'b0) g++;
        for (int i = 0; i < 8; i++) begin
            mon_bit(CPB, v, g, a);
            b[i] = v;
        end
`ifdef UART_TX_PARITY_EN
        mon_bit(CPB, v, g, a);
        if (v !== ^b) g++;
`endif
        mon_bit(CPB, v, g, a);
        if (v !== 1'b1) g++;
        if (a) return;
        n_frames++;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte %h, expected no frame", b);
        end else begin
            exp = sb.pop_front();
            check("frame_byte", {24'd0, b}, {24'd0, exp});
            check("frame_shape", 32'(g), 32'd0);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (!reset && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                receive_frame();
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0]  = '{ST,           32'h0,        1'b0, 32'h2, "rd_status"};
        vecs[1]  = '{BASE,         32'h0,        1'b0, 32'h0, "rd_txdata"};
        vecs[2]  = '{BASE + 32'd6, 32'h0,        1'b0, 32'h2, "rd_status_lowbits"};
        vecs[3]  = '{BASE + 32'd3, 32'h0,        1'b0, 32'h0, "rd_txdata_lowbits"};
        vecs[4]  = '{BASE + 32'd16, 32'h0,       1'b0, 32'h0, "rd_miss_16"};
        vecs[5]  = '{BASE + 32'd12, 32'h0,       1'b0, 32'h0, "rd_miss_12"};
        vecs[6]  = '{BASE + 32'd16, 32'hA5,      1'b1, 32'h0, "wr_miss_16"};
        vecs[7]  = '{BASE + 32'd8,  32'h5A,      1'b1, 32'h0, "wr_miss_8"};
        vecs[8]  = '{BASE - 32'd4,  32'h33,      1'b1, 32'h0, "wr_miss_below"};
        vecs[9]  = '{ST,           32'hFFFF_FFFF, 1'b1, 32'h2, "wr_status_all"};
        vecs[10] = '{BASE + 32'd20, 32'h11,      1'b1, 32'h0, "wr_miss_20"};
        vecs[11] = '{ST + 32'd1,   32'h0,        1'b0, 32'h2, "rd_status_after_misses"};

        reset = 1'b1; addr = ST; wdata = '0; we = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_status", read_data, 32'h2);
        reset = 1'b0;

        // Register decode and miss writes
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            #1 check(vecs[i].name, read_data, vecs[i].exp_rd);
        end
        idle_bus();
        lows = 0;
        repeat (2 * FC) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_frame_after_misses", 32'(lows), 32'd0);

        // Single byte: exact pop latency and frame shape
        starts.delete();
        drive(BASE, 32'hA5, 1'b1);
        w = cyc + 1;
        sb.push_back(8'hA5);
        idle_bus();
        #1 check("status_one_queued", read_data, 32'h100);
        @(posedge clk); #1;
        check("tx_high_at_pop", {31'd0, uart_tx}, 32'd1);
        check("status_after_pop", read_data, 32'h6);
        @(posedge clk); #1;
        check("tx_start_2_after_write", {31'd0, uart_tx}, 32'd0);
        drain("drain_a5", 3 * FC);
        check("a5_frames", 32'(starts.size()), 32'd1);
        if (starts.size() >= 1) check("a5_start_latency", 32'(starts[0] - w), 32'd2);

        // Three consecutive writes: gapless frames, busy throughout, count 2,1,0
        starts.delete();
        for (int i = 0; i < 3; i++) begin
            drive(BASE, 32'(8'h61 + i), 1'b1);
            if (i == 0) w = cyc + 1;
            sb.push_back(8'(8'h61 + i));
        end
        idle_bus();
        zeros = 0;
        for (int c = w + 2; c <= w + 3 * FC; c++) begin
            #1;
            if (read_data[2] !== 1'b1) zeros++;
            if (c == w + 2)          check("count_frame1", {24'd0, read_data[15:8]}, 32'd2);
            if (c == w + 1 + FC)     check("count_frame2", {24'd0, read_data[15:8]}, 32'd1);
            if (c == w + 1 + 2 * FC) check("count_frame3", {24'd0, read_data[15:8]}, 32'd0);
            @(negedge clk);
        end
        check("busy_throughout", 32'(zeros), 32'd0);
        #1 check("idle_after_burst", read_data, 32'h2);
        drain("drain_burst3", 3 * FC);
        check("burst3_frames", 32'(starts.size()), 32'd3);
        if (starts.size() >= 3) begin
            check("burst3_latency", 32'(starts[0] - w), 32'd2);
            check("burst3_gap1", 32'(starts[1] - starts[0]), 32'(FC));
            check("burst3_gap2", 32'(starts[2] - starts[1]), 32'(FC));
        end

        // Overflow: 10 writes, 9 accepted (one pops immediately), then clear and push-on-pop
        for (int i = 0; i < 10; i++) begin
            drive(BASE, 32'(8'h10 + i), 1'b1);
            if (i == 0) w = cyc + 1;
            if (i < 9) sb.push_back(8'(8'h10 + i));
        end
        drive(ST, 32'h8, 1'b1);
        #1 check("status_full_overflow", read_data, 32'h80D);
        idle_bus();
        #1 check("status_overflow_cleared", read_data, 32'h805);
        wait_until(w + FC - 1);
        drive(BASE, 32'hEE, 1'b1);
        sb.push_back(8'hEE);
        idle_bus();
        #1 check("push_on_pop_when_full", read_data, 32'h805);
        drain("drain_overflow", 12 * FC);

        // Reset in the middle of a data bit
        drive(BASE, 32'h3C, 1'b1);
        w = cyc + 1;
        drive(BASE, 32'h81, 1'b1);
        drive(BASE, 32'h7E, 1'b1);
        sb.push_back(8'h3C); sb.push_back(8'h81); sb.push_back(8'h7E);
        idle_bus();
        wait_until(w + 11);
        check("line_low_before_reset", {31'd0, uart_tx}, 32'd0);
        #1 reset = 1'b1;
        #1 check("reset_async_tx", {31'd0, uart_tx}, 32'd1);
        sb.delete();
        frames_before = n_frames;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 check("status_after_reset", read_data, 32'h2);
        lows = 0;
        repeat (3 * FC) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_tx_after_reset", 32'(lows), 32'd0);
        check("no_frames_after_reset", 32'(n_frames - frames_before), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral on the core's data bus, downstream of the multicycle core. It decodes `memory_address`, `memory_data_out` and `memory_write_enable`, buffers bytes in a small FIFO and serialises them 8N1 on `uart_tx`. It returns status on `read_data`, which the top level muxes into the core's `memory_data_in`.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: word-aligned base of the 8-byte register window.
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..64.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `memory_address`, input, 32: byte address from core.
- `memory_data_out`, input, 32: write data from core.
- `memory_write_enable`, input, 1: write strobe from core, one cycle per store.
- `read_data`, output, 32: combinational read data for the decoded address.
- `uart_tx`, output, 1: serial line, idle high.

## Operation
- Window hit: `memory_address[31:3] == BASE_ADDR[31:3]`. Register select is `memory_address[2]`. Bits [1:0] are ignored.
- Offset 0, TXDATA:
  - Write with FIFO not full: pushes `memory_data_out[7:0]`.
  - Write with FIFO full: byte dropped, sticky `overflow` set.
  - Read returns 0.
- Offset 4, STATUS, read fields:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `busy`, meaning the FSM is not IDLE
  - bit3 `overflow`
  - bits[15:8] FIFO count, zero-extended
  - other bits 0
- STATUS write with `memory_data_out[3]=1`: clears `overflow`. Other bits of the write are ignored.
- Miss: `read_data = 0`. Writes have no effect.
- FIFO: circular buffer.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop head into shift register, go START.
  - START: `uart_tx=0` for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles. Bit index counts 0..7, then STOP (or PARITY, see Configuration).
  - STOP: `uart_tx=1` for CLKS_PER_BIT cycles. At the end: if FIFO not empty, pop and go START directly with no gap; else go IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. It is cleared on every state change.

## Timing
- Reset values:
  - `uart_tx=1`, FSM IDLE, FIFO empty, count 0, `overflow=0`.
  - With STATUS addressed, `read_data` reads 32'h0000_0002.
- Reset is asynchronous. Asserting it mid-frame drives `uart_tx` high immediately and discards FIFO contents.
- Write takes effect at the `clk` edge where `memory_write_enable=1`. Count and STATUS reflect it from the next cycle.
- Pop latency:
  - A byte written into an empty FIFO while IDLE is popped on the following edge.
  - `uart_tx` falls one cycle after that pop.
  - First start bit therefore begins 2 cycles after the write edge.
- Back-to-back frames start exactly 10×CLKS_PER_BIT cycles apart, or 11× with parity.
- Push and pop on the same edge:
  - FIFO full: the push is accepted (a slot frees), count unchanged, `overflow` not set.
  - FIFO empty: no pop that edge. The pushed byte pops on the next eligible edge.
- Setting and clearing `overflow` on the same edge (overflowing push plus clear write is impossible on one bus, but an internal set and a clear can coincide): set wins.
- `read_data` is purely combinational from `memory_address` and current state, with no added latency.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state sits between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits.
  - Undefined: no PARITY state; DATA goes straight to STOP. Frame is 10 bits.
  - STATUS layout is identical either way.

## Test plan
- Reset then read BASE+4 -> `read_data=32'h0000_0002`; `uart_tx=1`.
- CLKS_PER_BIT=4, write 8'hA5 to BASE+0 -> line low 4 cycles starting 2 cycles after the write. Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. With parity: parity bit 0 before stop.
- Write 3 bytes consecutively -> three frames with no idle gap between them; `busy=1` throughout; count reads 2,1,0 as frames start.
- FIFO_DEPTH=8, with TX stalled by large CLKS_PER_BIT: write 10 bytes -> `full=1`, count=7 or 8 per pop timing, `overflow=1`. Only the first accepted bytes are transmitted, in order. Write 32'h8 to BASE+4 -> `overflow=0`.
- Assert `reset` during DATA of a frame -> `uart_tx=1` in the same cycle; STATUS reads 32'h0000_0002 after reset release; no further frames.
- Write to BASE+16 -> FIFO unchanged; read of that address returns 0.
